operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
Register-read side of the decode stage. Drives the register file's two read addresses and takes its combinational read data. Bypasses same-cycle Execute and Writeback writes, which the register file only commits at the clock edge. Detects load-use and back-to-back hazards and holds the resolved operands in a valid/ready pipeline register feeding Execute.

Parameters:
XLEN, 32, datapath width
AW, 5, register address width (32 architectural registers, x0 hard-wired zero)
SCW, 16, width of saturating stall counter

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of held/incoming instruction (branch redirect)
in_valid  in  1  decode has an instruction
in_ready  out  1  operand_fetch accepts this cycle
rs1, rs2  in  AW  source registers
rs1_used, rs2_used  in  1  source actually read by instruction
rd  in  AW  destination register
rd_we  in  1  instruction writes rd
is_load  in  1  instruction is a load
A1, A2  out  AW  register file read addresses
RD1, RD2  in  XLEN  register file read data
RegWE_E  in  1  Execute write enable
A3  in  AW  Execute destination
WD3  in  XLEN  Execute write data
E_is_load  in  1  Execute-stage instruction is a load (WD3 not yet valid)
RegWE_W  in  1  Writeback write enable
A4  in  AW  Writeback destination
WD4  in  XLEN  Writeback write data
out_valid  out  1  held instruction valid
out_ready  in  1  Execute accepts
op1, op2  out  XLEN  resolved operands
out_rd  out  AW  held destination
out_rd_we  out  1  held write enable
out_is_load  out  1  held load flag
stall_cnt  out  SCW  cycles with in_valid=1 and in_ready=0, saturating

Behaviour:
- Reset (reset_n low, async): out_valid=0, op1=op2=0, out_rd=0, out_rd_we=0, out_is_load=0, stall_cnt=0. in_ready is combinational and follows the rules below.
- Address path, combinational: A1=rs1, A2=rs2, always, including during stalls.
- Operand selection per source, in priority order:
  1. rs==0 -> 0.
  2. RegWE_E && !E_is_load && A3==rs -> WD3.
  3. RegWE_W && A4==rs -> WD4.
  4. Otherwise RDn.
- Execute beats Writeback when both match, newest wins. A3==0 or A4==0 never bypasses.
- Hazard, evaluated per used source rs (rs_used && rs!=0):
  - load-use: RegWE_E && E_is_load && A3==rs.
  - back-to-back: out_valid && out_rd_we && out_rd==rs (the producer has not reached Execute yet).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Capture: on in_valid && in_ready, the pipeline register loads the resolved op1/op2, rd, rd_we and is_load at the edge, and out_valid becomes 1. Latency is 1 cycle from accept to out_valid.
- Drain: out_valid && out_ready with no accept -> out_valid=0 next edge. Accept and drain in the same cycle -> out_valid stays 1 with the new contents (full throughput).
- Hold: out_valid && !out_ready -> all outputs stable.
- Flush: out_valid=0 next edge and no capture that cycle. Flush has priority over accept and drain. out_rd/op* hold their values; only out_valid is cleared.
- Unused sources (rsN_used=0) never cause hazards. The operand value is still produced.
- stall_cnt increments when in_valid && !in_ready && !flush, and saturates at 2^SCW-1.
- reset_n asserted mid-transfer discards the held instruction immediately.

Test Plan:
- No hazards: rs1=5, rs2=6, RD1=0x11, RD2=0x22, out_ready=1 -> next cycle op1=0x11, op2=0x22, out_valid=1. Back-to-back independent instructions accepted every cycle.
- Bypass priority: rs1=7 with RegWE_E=1, A3=7, WD3=0xAAAA and RegWE_W=1, A4=7, WD4=0xBBBB -> op1=0xAAAA. Drop RegWE_E -> op1=0xBBBB. Repeat with rs1=0 and A3=0 -> op1=0.
- Load-use: E_is_load=1, RegWE_E=1, A3=9, decode rs2=9 used -> in_ready=0 for one cycle and stall_cnt=1. Next cycle W bypass A4=9, WD4=0x1234 -> op2=0x1234.
- Back-to-back dependency: held out_rd=3, out_rd_we=1, decode rs1=3 -> in_ready=0. The producer moves to Execute and the Execute bypass supplies WD3 on the following accept. Same case with rs1_used=0 -> no stall.
- Backpressure and flush: out_ready=0 for 3 cycles -> outputs stable, in_ready=0. Assert flush together with in_valid -> out_valid=0 next edge and nothing captured.
- Reset mid-hold: reset_n low asynchronously while out_valid=1 -> out_valid, op1 and stall_cnt read 0 before the next clk edge.

Source files
------------

// File: rtl/operand_fetch.sv
// Decode-stage operand fetch: register-file read, E/W bypass, load-use and
// back-to-back hazard detection, and a valid/ready register feeding Execute.
module operand_fetch #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int SCW  = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic            rs1_used,
  input  logic            rs2_used,
  input  logic [AW-1:0]   rd,
  input  logic            rd_we,
  input  logic            is_load,
  output logic [AW-1:0]   A1,
  output logic [AW-1:0]   A2,
  input  logic [XLEN-1:0] RD1,
  input  logic [XLEN-1:0] RD2,
  input  logic            RegWE_E,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            E_is_load,
  input  logic            RegWE_W,
  input  logic [AW-1:0]   A4,
  input  logic [XLEN-1:0] WD4,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_we,
  output logic            out_is_load,
  output logic [SCW-1:0]  stall_cnt
);

  logic            r_valid;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [AW-1:0]   r_rd;
  logic            r_rd_we;
  logic            r_is_load;
  logic [SCW-1:0]  r_stall;

  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic            w_haz1;
  logic            w_haz2;
  logic            w_hazard;
  logic            w_accept;

  // Newest producer wins: Execute (unless its data is a pending load) over
  // Writeback over the register file, which only commits at the edge.
  function automatic logic [XLEN-1:0] resolve(
    input logic [AW-1:0]   rs,
    input logic [XLEN-1:0] rf,
    input logic            we_e,
    input logic            ld_e,
    input logic [AW-1:0]   a_e,
    input logic [XLEN-1:0] d_e,
    input logic            we_w,
    input logic [AW-1:0]   a_w,
    input logic [XLEN-1:0] d_w
  );
    logic [XLEN-1:0] v;
    if (rs == '0)                         v = '0;
    else if (we_e && !ld_e && a_e == rs)  v = d_e;
    else if (we_w && a_w == rs)           v = d_w;
    else                                  v = rf;
    return v;
  endfunction

  function automatic logic hazard_of(
    input logic          used,
    input logic [AW-1:0] rs,
    input logic          we_e,
    input logic          ld_e,
    input logic [AW-1:0] a_e,
    input logic          hv,
    input logic          hwe,
    input logic [AW-1:0] hrd
  );
    logic h;
    h = 1'b0;
    if (used && rs != '0) begin
      if (we_e && ld_e && a_e == rs) h = 1'b1;
      if (hv && hwe && hrd == rs)    h = 1'b1;
    end
    return h;
  endfunction

  always_comb begin
    w_op1  = resolve(rs1, RD1, RegWE_E, E_is_load, A3, WD3, RegWE_W, A4, WD4);
    w_op2  = resolve(rs2, RD2, RegWE_E, E_is_load, A3, WD3, RegWE_W, A4, WD4);
    w_haz1 = hazard_of(rs1_used, rs1, RegWE_E, E_is_load, A3, r_valid, r_rd_we, r_rd);
    w_haz2 = hazard_of(rs2_used, rs2, RegWE_E, E_is_load, A3, r_valid, r_rd_we, r_rd);
  end

  assign w_hazard = w_haz1 || w_haz2;
  assign in_ready = !flush && !w_hazard && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  assign A1          = rs1;
  assign A2          = rs2;
  assign out_valid   = r_valid;
  assign op1         = r_op1;
  assign op2         = r_op2;
  assign out_rd      = r_rd;
  assign out_rd_we   = r_rd_we;
  assign out_is_load = r_is_load;
  assign stall_cnt   = r_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_rd      <= '0;
      r_rd_we   <= 1'b0;
      r_is_load <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_op1     <= w_op1;
      r_op2     <= w_op2;
      r_rd      <= rd;
      r_rd_we   <= rd_we;
      r_is_load <= is_load;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall <= '0;
    end else if (in_valid && !in_ready && !flush && r_stall != '1) begin
      r_stall <= r_stall + 1'b1;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: expected operands queued at accept,
// compared when Execute takes the held instruction.
module tb_operand_fetch;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int SCW  = 4;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [AW-1:0]   rd;
    logic            we;
    logic            ld;
  } exp_t;

  logic            clk, reset_n, flush, in_valid, in_ready;
  logic [AW-1:0]   rs1, rs2, rd, A1, A2, A3, A4, out_rd;
  logic            rs1_used, rs2_used, rd_we, is_load;
  logic [XLEN-1:0] RD1, RD2, WD3, WD4, op1, op2;
  logic            RegWE_E, E_is_load, RegWE_W;
  logic            out_valid, out_ready, out_rd_we, out_is_load;
  logic [SCW-1:0]  stall_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];

  operand_fetch #(.XLEN(XLEN), .AW(AW), .SCW(SCW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd(rd), .rd_we(rd_we), .is_load(is_load),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .RegWE_E(RegWE_E), .A3(A3), .WD3(WD3), .E_is_load(E_is_load),
    .RegWE_W(RegWE_W), .A4(A4), .WD4(WD4),
    .out_valid(out_valid), .out_ready(out_ready),
    .op1(op1), .op2(op2), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_is_load(out_is_load), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bypass_off();
    RegWE_E = 0; E_is_load = 0; A3 = '0; WD3 = '0;
    RegWE_W = 0; A4 = '0; WD4 = '0;
  endtask

  task automatic drive(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                       input logic u1, input logic u2,
                       input logic [AW-1:0] d, input logic we, input logic ld,
                       input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2);
    in_valid = 1; rs1 = s1; rs2 = s2; rs1_used = u1; rs2_used = u2;
    rd = d; rd_we = we; is_load = ld; RD1 = r1; RD2 = r2;
    #1;
  endtask

  task automatic accept(input string tag, input logic exp_rdy, input exp_t e);
    check(tag, in_ready, exp_rdy);
    if (exp_rdy) q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Execute takes (or flush discards) the held instruction at the next edge.
  always @(negedge clk) begin
    if (reset_n && out_valid && (flush || out_ready)) begin
      check("sb_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        if (!flush) begin
          check("sb_op1", op1, e.op1);
          check("sb_op2", op2, e.op2);
          check("sb_rd", out_rd, e.rd);
          check("sb_rd_we", out_rd_we, e.we);
          check("sb_is_load", out_is_load, e.ld);
        end
      end
    end
  end

  initial begin
    reset_n = 0; flush = 0; in_valid = 0; out_ready = 1;
    rs1 = '0; rs2 = '0; rs1_used = 0; rs2_used = 0;
    rd = '0; rd_we = 0; is_load = 0; RD1 = '0; RD2 = '0;
    bypass_off();
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_op1", op1, 0);
    check("rst_op2", op2, 0);
    check("rst_rd", out_rd, 0);
    check("rst_rd_we", out_rd_we, 0);
    check("rst_is_load", out_is_load, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    #8 reset_n = 1;
    @(posedge clk); #1;

    // independent instructions, one per cycle
    drive(5, 6, 1, 1, 10, 1, 0, 32'h11, 32'h22);
    check("addr_A1", A1, 5);
    check("addr_A2", A2, 6);
    accept("nohaz0", 1, '{32'h11, 32'h22, 5'd10, 1'b1, 1'b0});
    check("nohaz_valid", out_valid, 1);
    drive(1, 2, 1, 1, 11, 1, 0, 32'h33, 32'h44);
    accept("nohaz1", 1, '{32'h33, 32'h44, 5'd11, 1'b1, 1'b0});
    drive(4, 8, 1, 1, 12, 1, 0, 32'h55, 32'h66);
    accept("nohaz2", 1, '{32'h55, 32'h66, 5'd12, 1'b1, 1'b0});

    // bypass priority
    RegWE_E = 1; A3 = 7; WD3 = 32'hAAAA; RegWE_W = 1; A4 = 7; WD4 = 32'hBBBB;
    drive(7, 0, 1, 1, 13, 1, 0, 32'h77, 32'hDEAD);
    accept("byp_e", 1, '{32'hAAAA, 32'h0, 5'd13, 1'b1, 1'b0});
    RegWE_E = 0;
    drive(7, 0, 1, 1, 14, 1, 0, 32'h77, 32'hDEAD);
    accept("byp_w", 1, '{32'hBBBB, 32'h0, 5'd14, 1'b1, 1'b0});
    RegWE_E = 1; A3 = 0; A4 = 0;
    drive(0, 5, 1, 1, 15, 1, 0, 32'h1111, 32'h55);
    accept("byp_x0", 1, '{32'h0, 32'h55, 5'd15, 1'b1, 1'b0});
    A3 = 6; A4 = 5;
    drive(5, 6, 1, 1, 16, 1, 0, 32'h50, 32'h60);
    accept("byp_split", 1, '{32'hBBBB, 32'hAAAA, 5'd16, 1'b1, 1'b0});
    bypass_off();
    check("stall_none", stall_cnt, 0);

    // load-use
    RegWE_E = 1; E_is_load = 1; A3 = 9; WD3 = 32'hBAD;
    drive(1, 9, 1, 1, 17, 1, 1, 32'h1, 32'h999);
    accept("lu_stall", 0, '0);
    check("lu_cnt", stall_cnt, 1);
    bypass_off();
    RegWE_W = 1; A4 = 9; WD4 = 32'h1234;
    drive(1, 9, 1, 1, 17, 1, 1, 32'h1, 32'h999);
    accept("lu_go", 1, '{32'h1, 32'h1234, 5'd17, 1'b1, 1'b1});
    bypass_off();
    RegWE_E = 1; E_is_load = 1; A3 = 2; WD3 = 32'hBAD;
    drive(2, 0, 0, 1, 18, 1, 0, 32'h22, 32'h0);
    accept("lu_unused", 1, '{32'h22, 32'h0, 5'd18, 1'b1, 1'b0});
    bypass_off();

    // back-to-back dependency
    drive(0, 0, 0, 0, 3, 1, 0, 32'h0, 32'h0);
    accept("b2b_prod", 1, '{32'h0, 32'h0, 5'd3, 1'b1, 1'b0});
    drive(3, 4, 1, 1, 19, 1, 0, 32'h3BAD, 32'h44);
    accept("b2b_stall", 0, '0);
    check("b2b_cnt", stall_cnt, 2);
    RegWE_E = 1; A3 = 3; WD3 = 32'hC0DE;
    drive(3, 4, 1, 1, 19, 1, 0, 32'h3BAD, 32'h44);
    accept("b2b_go", 1, '{32'hC0DE, 32'h44, 5'd19, 1'b1, 1'b0});
    bypass_off();
    drive(0, 0, 0, 0, 3, 1, 0, 32'h0, 32'h0);
    accept("b2b_prod2", 1, '{32'h0, 32'h0, 5'd3, 1'b1, 1'b0});
    drive(3, 4, 0, 1, 20, 1, 0, 32'h333, 32'h44);
    accept("b2b_unused", 1, '{32'h333, 32'h44, 5'd20, 1'b1, 1'b0});
    check("b2b_unused_cnt", stall_cnt, 2);

    // backpressure, then flush
    drive(2, 0, 1, 0, 21, 1, 0, 32'h2222, 32'h0);
    accept("bp_load", 1, '{32'h2222, 32'h0, 5'd21, 1'b1, 1'b0});
    out_ready = 0;
    drive(4, 5, 1, 1, 22, 1, 0, 32'h4, 32'h5);
    for (int i = 0; i < 3; i++) begin
      accept("bp_stall", 0, '0);
      check("bp_valid", out_valid, 1);
      check("bp_op1", op1, 32'h2222);
      check("bp_rd", out_rd, 21);
    end
    check("bp_cnt", stall_cnt, 5);
    flush = 1; #1;
    accept("fl_ready", 0, '0);
    flush = 0;
    check("fl_valid", out_valid, 0);
    check("fl_op1_hold", op1, 32'h2222);
    check("fl_rd_hold", out_rd, 21);
    check("fl_cnt", stall_cnt, 5);
    check("fl_sb_drained", q.size(), 0);

    // saturation of the stall counter
    drive(4, 5, 1, 1, 22, 1, 0, 32'h4, 32'h5);
    accept("sat_load", 1, '{32'h4, 32'h5, 5'd22, 1'b1, 1'b0});
    for (int i = 0; i < 10; i++) accept("sat_stall", 0, '0);
    check("sat_max", stall_cnt, 15);
    accept("sat_stall", 0, '0);
    check("sat_hold", stall_cnt, 15);

    // asynchronous reset while holding
    in_valid = 0;
    check("rr_valid_pre", out_valid, 1);
    #2 reset_n = 0;
    #1;
    check("rr_valid", out_valid, 0);
    check("rr_op1", op1, 0);
    check("rr_rd", out_rd, 0);
    check("rr_cnt", stall_cnt, 0);
    q.delete();
    #10 reset_n = 1;
    out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("post_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
